// File: rtl/pipei_pkg.sv
// pipei_pkg: state and character-class enums plus ASCII constants for pipei_fsm.
package pipei_pkg;
  typedef enum logic [2:0] {IDLE, OPND1, OPR, OPND2, MATCH} state_t;
  typedef enum logic [2:0] {SPACE, OPND, OP, EQ, OTHER} cls_t;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_EQ    = 8'h3d;
  localparam logic [7:0] CH_PLUS  = 8'h2b;
  localparam logic [7:0] CH_MINUS = 8'h2d;
  localparam logic [7:0] CH_STAR  = 8'h2a;
  localparam logic [7:0] CH_SLASH = 8'h2f;
endpackage

// File: rtl/pipei_char_class.sv
// pipei_char_class: combinational ASCII classifier into SPACE/OPND/OP/EQ/OTHER.
module pipei_char_class
  import pipei_pkg::*;
(
  input  logic [7:0] c,
  output cls_t       cls
);
  logic opnd, op;
  always_comb begin
    opnd = (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h5a) || (c >= 8'h61 && c <= 8'h7a);
    op   = c == CH_PLUS || c == CH_MINUS || c == CH_STAR || c == CH_SLASH;
    cls  = c == CH_SPACE ? SPACE : opnd ? OPND : op ? OP : c == CH_EQ ? EQ : OTHER;
  end
endmodule

// File: rtl/pipei_fsm.sv
// pipei_fsm: recognises "operand op operand =" in a byte stream, spaces ignored.
// Define PIPEI_FSM_MULTI_DIGIT_EN to let consecutive operand characters form one operand.
module pipei_fsm
  import pipei_pkg::*;
#(
  parameter int CHAR_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [CHAR_W-1:0] in,
  output logic              out
);
`ifdef PIPEI_FSM_MULTI_DIGIT_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif
  cls_t   cls;
  state_t st, nxt;
  pipei_char_class u_cls (.c(in), .cls(cls));
  // An unexpected operand restarts an expression; anything else unexpected drops to IDLE.
  always_comb begin
    nxt = IDLE;
    if (cls == SPACE) nxt = st == MATCH ? IDLE : st;
    else begin
      case (st)
        IDLE:    nxt = cls == OPND ? OPND1 : IDLE;
        OPND1:   nxt = cls == OP ? OPR : cls == OPND ? OPND1 : IDLE;
        OPR:     nxt = cls == OPND ? OPND2 : IDLE;
        OPND2:   nxt = cls == EQ ? MATCH : cls == OPND ? (MULTI ? OPND2 : OPND1) : IDLE;
        MATCH:   nxt = cls == OPND ? OPND1 : IDLE;
        default: nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) st <= IDLE;
    else st <= nxt;
  assign out = st == MATCH;
endmodule

// File: tb/tb_pipei_fsm.sv
// tb_pipei_fsm: directed and random character streams checked against a grammar-level model.
module tb_pipei_fsm;
  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] din;
  logic       out;
  int vecs = 0;
  int errs = 0;
  int pulses = 0;
  byte unsigned expr[$];
  bit done;
`ifdef PIPEI_FSM_MULTI_DIGIT_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif
  pipei_fsm dut (.clk(clk), .clr(clr), .in(din), .out(out));
  always #5 clk = ~clk;
  function automatic bit is_opnd(byte unsigned c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction
  function automatic bit is_op(byte unsigned c);
    return c == "+" || c == "-" || c == "*" || c == "/";
  endfunction
  // expr holds the non-space characters of the current attempt; is it a prefix of O+ P O+ '=' ?
  function automatic bit well_formed();
    int n = expr.size();
    int i = 0;
    int a = 0;
    int b = 0;
    while (i < n && is_opnd(expr[i])) begin a++; i++; end
    if (a == 0) return n == 0;
    if (!MULTI && a > 1) return 0;
    if (i == n) return 1;
    if (!is_op(expr[i])) return 0;
    i++;
    while (i < n && is_opnd(expr[i])) begin b++; i++; end
    if (!MULTI && b > 1) return 0;
    if (i == n) return 1;
    if (b == 0 || expr[i] != "=") return 0;
    return i == n - 1;
  endfunction
  task automatic step(byte unsigned c);
    if (done) begin expr.delete(); done = 0; end
    if (c != 8'h20) begin
      expr.push_back(c);
      if (!well_formed()) begin
        expr.delete();
        if (is_opnd(c)) expr.push_back(c);
      end
      done = expr.size() > 0 && expr[expr.size()-1] == "=";
    end
  endtask
  task automatic chk(string tag, int obs, int exp);
    vecs++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic send(byte unsigned c, string tag);
    @(negedge clk);
    din = c;
    @(posedge clk);
    step(c);
    #1;
    chk(tag, int'(out), int'(done));
    if (out) pulses++;
  endtask
  task automatic send_str(string s, string tag);
    for (int i = 0; i < s.len(); i++) send(s[i], tag);
  endtask
  task automatic clr_pulse(string tag);
    @(negedge clk);
    #2 clr = 1'b1;
    #1 chk(tag, int'(out), 0);
    expr.delete();
    done = 0;
    #1 clr = 1'b0;
  endtask
  initial begin
    string alpha = "ab9Z+-*/=   =#.";
    int r;
    clr = 1'b1;
    din = 8'h00;
    done = 0;
    repeat (10) begin
      @(negedge clk);
      chk("reset", int'(out), 0);
    end
    clr = 1'b0;
    pulses = 0;
    send_str("  + 0=c/A=", "basic");
    chk("basic_pulses", pulses, 1);
    pulses = 0;
    send_str("a +  b =", "spaces");
    chk("spaces_pulses", pulses, 1);
    pulses = 0;
    send_str("1+2=3*4=", "b2b");
    chk("b2b_pulses", pulses, 2);
    send_str("x-", "pre_clr");
    clr_pulse("mid_clr");
    pulses = 0;
    send_str("y=", "post_clr");
    chk("post_clr_pulses", pulses, 0);
    send_str("1+2=", "pre_match_clr");
    clr_pulse("match_clr");
    pulses = 0;
    send_str("ab+12=", "multi");
    chk("multi_pulses", pulses, MULTI ? 1 : 0);
    pulses = 0;
    send_str("a#b=", "other");
    chk("other_pulses", pulses, 0);
    repeat (3000) begin
      if ($urandom_range(0, 99) == 0) clr_pulse("rnd_clr");
      else begin
        r = int'($urandom_range(0, 19));
        send(r < alpha.len() ? alpha[r] : 8'($urandom_range(0, 255)), "rnd");
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/pipei_fsm.md
Name: pipei_fsm

Overview:
- Byte-serial ASCII pattern-matching FSM.
- Consumes one 8-bit character per clock.
- Asserts `out` when the stream has just completed a simple binary expression of the form `operand op operand =`, with spaces ignored.
- Sits behind a character source (UART/stream front end) as a lightweight lexical recogniser.

Parameters:
- CHAR_W, 8, character width in bits. Only 8 is supported; the classifier uses ASCII codes.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- clr  input  1  reset; asynchronous, active-high; forces state IDLE and out=0
- in   input  8  ASCII character, sampled every rising edge when clr=0
- out  output 1  match flag; Moore output, high while state==MATCH

Behaviour:
- Character classes:
  - SPACE: 0x20.
  - OPND: '0'-'9', 'A'-'Z', 'a'-'z'.
  - OP: '+', '-', '*', '/'.
  - EQ: '='.
  - OTHER: every remaining code, including 0x00.
- States: IDLE (expect operand), OPND1 (expect op), OPR (expect operand), OPND2 (expect '='), MATCH.
- SPACE in any state except MATCH: hold state.
- SPACE in MATCH: go to IDLE.
- Transitions:
  - IDLE: OPND->OPND1; OP/EQ/OTHER->IDLE.
  - OPND1: OP->OPR; OPND->OPND1 (restart with new operand); EQ/OTHER->IDLE.
  - OPR: OPND->OPND2; OP/EQ/OTHER->IDLE.
  - OPND2: EQ->MATCH; OPND->OPND1 (restart); OP/OTHER->IDLE.
  - MATCH: OPND->OPND1; all else->IDLE.
- Error recovery rule: an unexpected OPND is treated as the start of a new expression. Any other unexpected class returns to IDLE.
- Timing and output:
  - out=1 in the cycle after the edge that samples the terminating '='.
  - out stays high exactly one cycle per match, since MATCH always exits on the next edge.
- Reset:
  - clr=1 immediately (asynchronously) sets state=IDLE and out=0, including mid-expression.
  - The first edge after clr falls samples `in` normally.
- No handshake; every edge with clr=0 consumes one character.

Optional Feature:
- Macro: PIPEI_FSM_MULTI_DIGIT_EN.
- Defined: consecutive OPND characters form one operand.
  - OPND in OPND1 holds OPND1.
  - OPND in OPND2 holds OPND2.
  - Example: "ab+12=" matches.
- Undefined: operands are single characters.
  - OPND in OPND1 restarts at OPND1.
  - OPND in OPND2 restarts at OPND1.
  - "ab+12=" therefore does not match.
- All other behaviour is identical with or without the macro.

Decomposition:
- Package pipei_pkg holds:
  - State enum: IDLE, OPND1, OPR, OPND2, MATCH.
  - Char-class enum: SPACE, OPND, OP, EQ, OTHER.
  - ASCII constants: space, '=', '+', '-', '*', '/'.
- Sub-module pipei_char_class: purely combinational, maps in[7:0] to the class enum.
- FSM next-state logic, state register and Moore output stay in pipei_fsm.

Test Plan:
- Reset: clr=1 for 100 ns with in=0 -> out=0 throughout.
- Basic match with recovery: after clr=0, feed " "," ","+"," ","0","=","c","/","A","=" one per cycle.
  - Expected path: state IDLE,IDLE,IDLE,IDLE,OPND1,IDLE,OPND1,OPR,OPND2,MATCH.
  - out=1 for exactly the one cycle after the final '=' edge, 0 everywhere else.
- Spaces ignored: "a"," ","+"," "," ","b"," ","=" -> out=1 for one cycle after '='.
- Back-to-back matches: "1+2=3*4=" -> out pulses twice, one cycle each.
  - Direct MATCH->OPND1 on '3' is exercised.
- Async reset mid-expression: "x","-" then pulse clr between edges, then "y","=".
  - out drops immediately and the state is IDLE.
  - No match occurs, since "y=" alone is invalid.
- Multi-char operands, "ab+12=":
  - With PIPEI_FSM_MULTI_DIGIT_EN: out=1 once.
  - Without it: out stays 0.
  - Also "a#b=" -> out=0 in both builds (OTHER returns to IDLE).
